// File: rtl/seg_display.sv
// Memory-mapped eight-digit seven-segment scanner: CPU writes DATA/CTRL, the
// block cycles through digits with a short all-off gap at the start of each slot.
module seg_display #(
  parameter int SCAN_DIV  = 20000,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST      = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK     = CW'(BLANK_CYC);
  localparam logic [31:0]   CTRL_MASK = 32'h00FF_FF01;

  logic [31:0]   data_reg;
  logic [31:0]   ctrl_reg;
  logic [CW-1:0] div_cnt_reg;
  logic [2:0]    idx_reg;
  logic [3:0]    nibble [8];
  logic [7:0]    digit_mask;
  logic [7:0]    dp_mask;
  logic          lit;
  logic [6:0]    glyph;
  logic [7:0]    dig_en_next;
  logic [7:0]    seg_next;
  logic          unused_addr;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_nibble
      assign nibble[gi] = data_reg[4*gi +: 4];
    end
  endgenerate

  assign digit_mask  = ctrl_reg[15:8];
  assign dp_mask     = ctrl_reg[23:16];
  assign rdata       = addr[2] ? ctrl_reg : data_reg;
  assign unused_addr = ^{addr[31:3], addr[1:0]};

  // Outputs are a pure function of the current scan state; the output
  // register below adds the single cycle of latency.
  always_comb begin
    lit         = 1'b0;
    glyph       = 7'h00;
    dig_en_next = 8'hFF;
    seg_next    = 8'hFF;
    lit = ctrl_reg[0] && (div_cnt_reg >= BLANK) && digit_mask[idx_reg];
    case (nibble[idx_reg])
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
    if (lit) begin
      dig_en_next = ~(8'd1 << idx_reg);
      seg_next    = {~dp_mask[idx_reg], ~glyph};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg    <= 32'h0;
      ctrl_reg    <= 32'h0000_FF01;
      div_cnt_reg <= '0;
      idx_reg     <= 3'd0;
      dig_en      <= 8'hFF;
      seg         <= 8'hFF;
    end else begin
      if (we) begin
        if (addr[2]) ctrl_reg <= wdata & CTRL_MASK;
        else         data_reg <= wdata;
      end
      if (div_cnt_reg == LAST) begin
        div_cnt_reg <= '0;
        idx_reg     <= idx_reg + 3'd1;
      end else begin
        div_cnt_reg <= div_cnt_reg + CW'(1);
      end
      dig_en <= dig_en_next;
      seg    <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_display.sv
// Self-checking bench for seg_display: cycle-count reference model of the scan,
// directed scenarios plus randomized register traffic.
module tb_seg_display;
  localparam int SD = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  seg_display #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata),
    .rdata(rdata), .dig_en(dig_en), .seg(seg)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: t = cycles since reset; slot and phase follow by arithmetic.
  int          t = 0;
  logic [31:0] m_data = 32'h0;
  logic [31:0] m_ctrl = 32'h0000_FF01;
  logic [7:0]  exp_dig = 8'hFF;
  logic [7:0]  exp_seg = 8'hFF;
  logic [6:0]  hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int cur_idx();
    return (t / SD) % 8;
  endfunction

  function automatic int cur_cnt();
    return t % SD;
  endfunction

  task automatic tick(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int cnt;
    int idx;
    logic [3:0] nib;
    rst = r; we = w; addr = a; wdata = d;
    @(posedge clk);
    if (r) begin
      t = 0; m_data = 32'h0; m_ctrl = 32'h0000_FF01;
      exp_dig = 8'hFF; exp_seg = 8'hFF;
    end else begin
      cnt = cur_cnt();
      idx = cur_idx();
      if (!m_ctrl[0] || cnt < BC || !m_ctrl[8+idx]) begin
        exp_dig = 8'hFF; exp_seg = 8'hFF;
      end else begin
        nib = m_data[4*idx +: 4];
        exp_dig = ~(8'd1 << idx);
        exp_seg = {~m_ctrl[16+idx], ~hex_tbl[nib]};
      end
      t++;
      if (w) begin
        if (a[2]) m_ctrl = d & 32'h00FF_FF01;
        else      m_data = d;
      end
    end
    #1;
    rst = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 32'h0, 32'h0);
    tick(1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF);
    tests++;
    if (dig_en !== 8'hFF) begin fails++; $display("FAIL reset_dig_en got %h want ff", dig_en); end
    tests++;
    if (seg !== 8'hFF) begin fails++; $display("FAIL reset_seg got %h want ff", seg); end
    addr = 32'h0; #1;
    tests++;
    if (rdata !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 00000000", rdata); end
    addr = 32'h4; #1;
    tests++;
    if (rdata !== 32'h0000_FF01) begin fails++; $display("FAIL reset_ctrl got %h want 0000ff01", rdata); end
    $display("[TB] reset checked");
  endtask

  task automatic test_full_scan();
    int lit_cnt [8];
    int prev_lit;
    int gap;
    for (int k = 0; k < 8; k++) lit_cnt[k] = 0;
    prev_lit = -1; gap = 99;
    tick(1'b0, 1'b1, 32'h0, 32'h7654_3210);
    addr = 32'h0; #1;
    tests++;
    if (rdata !== 32'h7654_3210) begin fails++; $display("FAIL scan_rdata got %h want 76543210", rdata); end
    for (int c = 0; c < 32; c++) begin
      tick(1'b0, 1'b0, 32'h0, 32'h0);
      tests++;
      if (dig_en !== exp_dig || seg !== exp_seg) begin
        fails++; $display("FAIL scan_out t=%0d got %h/%h want %h/%h", t, dig_en, seg, exp_dig, exp_seg);
      end
      tests++;
      if ($countones(~dig_en) > 1) begin fails++; $display("FAIL scan_onehot got %h want at most one low", dig_en); end
      if (dig_en == 8'hFF) gap++;
      for (int k = 0; k < 8; k++) begin
        if (dig_en == ~(8'd1 << k)) begin
          lit_cnt[k]++;
          if (prev_lit != k && prev_lit >= 0) begin
            tests++;
            if (gap < BC) begin fails++; $display("FAIL scan_gap got %0d want >= %0d", gap, BC); end
          end
          prev_lit = k; gap = 0;
        end
      end
      if (dig_en == 8'hFE) begin tests++; if (seg !== 8'hC0) begin fails++; $display("FAIL scan_seg0 got %h want c0", seg); end end
      if (dig_en == 8'hFD) begin tests++; if (seg !== 8'hF9) begin fails++; $display("FAIL scan_seg1 got %h want f9", seg); end end
      if (dig_en == 8'hFB) begin tests++; if (seg !== 8'hA4) begin fails++; $display("FAIL scan_seg2 got %h want a4", seg); end end
      if (dig_en == 8'h7F) begin tests++; if (seg !== 8'hF8) begin fails++; $display("FAIL scan_seg7 got %h want f8", seg); end end
    end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (lit_cnt[k] != SD - BC) begin
        fails++; $display("FAIL scan_lit_count digit %0d got %0d want %0d", k, lit_cnt[k], SD - BC);
      end
    end
    $display("[TB] full scan checked");
  endtask

  task automatic test_mask_dp();
    logic saw0, saw2;
    saw0 = 1'b0; saw2 = 1'b0;
    tick(1'b0, 1'b1, 32'h4, 32'h0001_0501);
    for (int c = 0; c < 40; c++) begin
      tick(1'b0, 1'b0, 32'h0, 32'h0);
      tests++;
      if (dig_en !== exp_dig || seg !== exp_seg) begin
        fails++; $display("FAIL mask_out t=%0d got %h/%h want %h/%h", t, dig_en, seg, exp_dig, exp_seg);
      end
      tests++;
      if (dig_en !== 8'hFF && dig_en !== 8'hFE && dig_en !== 8'hFB) begin
        fails++; $display("FAIL mask_digit got %h want ff/fe/fb", dig_en);
      end
      if (dig_en == 8'hFE) begin
        saw0 = 1'b1; tests++;
        if (seg[7] !== 1'b0) begin fails++; $display("FAIL mask_dp0 got %b want 0", seg[7]); end
      end
      if (dig_en == 8'hFB) begin
        saw2 = 1'b1; tests++;
        if (seg[7] !== 1'b1) begin fails++; $display("FAIL mask_dp2 got %b want 1", seg[7]); end
      end
      if (dig_en == 8'hFF) begin
        tests++;
        if (seg !== 8'hFF) begin fails++; $display("FAIL mask_blank_seg got %h want ff", seg); end
      end
    end
    tests++;
    if (!(saw0 && saw2)) begin fails++; $display("FAIL mask_seen got %b%b want 11", saw0, saw2); end
    $display("[TB] mask and dp checked");
  endtask

  task automatic test_disable();
    tick(1'b0, 1'b1, 32'h4, 32'h0000_FF01);
    for (int i = 0; i < 64 && !(cur_idx() == 3 && cur_cnt() == 2); i++) tick(1'b0, 1'b0, 32'h0, 32'h0);
    tick(1'b0, 1'b1, 32'h4, 32'h0);
    tests++;
    if (dig_en !== 8'hF7) begin fails++; $display("FAIL disable_prelit got %h want f7", dig_en); end
    for (int c = 0; c < 10; c++) begin
      tick(1'b0, 1'b0, 32'h4, 32'h0);
      tests++;
      if (dig_en !== 8'hFF || seg !== 8'hFF) begin
        fails++; $display("FAIL disable_blank got %h/%h want ff/ff", dig_en, seg);
      end
    end
    #1;
    tests++;
    if (rdata !== 32'h0) begin fails++; $display("FAIL disable_rdata got %h want 00000000", rdata); end
    $display("[TB] disable checked");
  endtask

  task automatic test_ctrl_mask();
    tick(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    addr = 32'h4; #1;
    tests++;
    if (rdata !== 32'h00FF_FF01) begin fails++; $display("FAIL ctrl_mask got %h want 00ff ff01", rdata); end
    addr = 32'hABCD_0010; #1;
    tests++;
    if (rdata !== m_data) begin fails++; $display("FAIL ctrl_mask_data got %h want %h", rdata, m_data); end
    $display("[TB] ctrl masking checked");
  endtask

  task automatic test_boundary();
    logic [31:0] nd;
    nd = $urandom;
    tick(1'b0, 1'b1, 32'h4, 32'h0000_FF01);
    tick(1'b0, 1'b1, 32'h0, $urandom);
    for (int i = 0; i < 64 && !(cur_idx() == 7 && cur_cnt() == SD - 1); i++) tick(1'b0, 1'b0, 32'h0, 32'h0);
    tick(1'b0, 1'b1, 32'h0, nd);
    tick(1'b0, 1'b0, 32'h0, 32'h0);
    tests++;
    if (dig_en !== 8'hFF) begin fails++; $display("FAIL wrap_blank got %h want ff", dig_en); end
    tick(1'b0, 1'b0, 32'h0, 32'h0);
    tests++;
    if (dig_en !== 8'hFE || seg !== {1'b1, ~hex_tbl[nd[3:0]]}) begin
      fails++; $display("FAIL wrap_digit0 got %h/%h want fe/%h", dig_en, seg, {1'b1, ~hex_tbl[nd[3:0]]});
    end
    for (int i = 0; i < 64 && cur_cnt() != 2; i++) tick(1'b0, 1'b0, 32'h0, 32'h0);
    tick(1'b1, 1'b0, 32'h0, 32'h0);
    tests++;
    if (dig_en !== 8'hFF || seg !== 8'hFF) begin fails++; $display("FAIL midreset got %h/%h want ff/ff", dig_en, seg); end
    tick(1'b0, 1'b0, 32'h0, 32'h0);
    tests++;
    if (dig_en !== 8'hFF) begin fails++; $display("FAIL postreset_blank got %h want ff", dig_en); end
    tick(1'b0, 1'b0, 32'h0, 32'h0);
    tests++;
    if (dig_en !== 8'hFE || seg !== 8'hC0) begin fails++; $display("FAIL postreset_lit got %h/%h want fe/c0", dig_en, seg); end
    $display("[TB] boundary write and reset checked");
  endtask

  task automatic test_random();
    logic        w;
    logic [31:0] a, d;
    for (int c = 0; c < 400; c++) begin
      w = ($urandom_range(0, 9) == 0);
      a = {$urandom, 2'b00} ^ ({$urandom} & 32'hFFFF_FFF8);
      d = $urandom;
      if (a[2] && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      tick(1'b0, w, a, d);
      tests++;
      if (dig_en !== exp_dig || seg !== exp_seg) begin
        fails++; $display("FAIL rand_out t=%0d got %h/%h want %h/%h", t, dig_en, seg, exp_dig, exp_seg);
      end
      tests++;
      if ($countones(~dig_en) > 1) begin fails++; $display("FAIL rand_onehot got %h want at most one low", dig_en); end
      addr = $urandom; #1;
      tests++;
      if (rdata !== (addr[2] ? m_ctrl : m_data)) begin
        fails++; $display("FAIL rand_rdata addr=%h got %h want %h", addr, rdata, addr[2] ? m_ctrl : m_data);
      end
    end
    $display("[TB] random traffic checked");
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_mask_dp();
    test_disable();
    test_ctrl_mask();
    test_boundary();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
